// File: rtl/priority_encoder_rr_if.sv
// Request/grant bundle between request sources, the encoder and its consumer.
// master drives requests and ready; slave (the encoder) returns the grant.
interface priority_encoder_rr_if #(
    parameter int N = 8,
    parameter int W = 3
);
    logic         E;
    logic [N-1:0] D;
    logic         MODE;
    logic         RDY;
    logic [W-1:0] S;
    logic         V;
    logic         MULTI;

    modport master (output E, D, MODE, RDY, input S, V, MULTI);
    modport slave  (input E, D, MODE, RDY, output S, V, MULTI);
endinterface

// File: rtl/priority_encoder_rr.sv
// N-to-log2(N) request encoder, fixed or round-robin priority, registered grant.
// Latency 1 cycle from load edge; grant held until RDY, back-to-back reload on handshake.
module priority_encoder_rr #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    priority_encoder_rr_if.slave  bus
);

    if (W != $clog2(N) || N < 2 || N > 256) begin : g_param_err
        $error("priority_encoder_rr: N must be 2..256 and W must equal clog2(N)");
    end

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_s;
    logic [W-1:0]   w_s_nxt;
    logic [W-1:0]   r_p;
    logic [W-1:0]   w_p_nxt;
    logic           r_multi;
    logic           w_multi_nxt;

    logic           w_load;
    logic           w_hs;
    logic           w_multi_hot;
    logic [W-1:0]   w_s_inc;
    logic [W-1:0]   w_p_scan;
    logic [W-1:0]   w_fix_idx;
    logic [W-1:0]   w_rr_idx;
    logic [W-1:0]   w_sel_idx;
    logic [W:0]     w_scan_idx;

    assign w_load      = bus.E && (bus.D != '0);
    assign w_hs        = (r_state == HOLD) && bus.RDY;
    assign w_multi_hot = ($countones(bus.D) > 1);
    assign w_s_inc     = (r_s == W'(N - 1)) ? '0 : r_s + 1'b1;

    // A reload on the handshake edge must already see the advanced pointer.
    assign w_p_scan  = (w_hs && bus.MODE) ? w_s_inc : r_p;
    assign w_sel_idx = bus.MODE ? w_rr_idx : w_fix_idx;

    always_comb begin
        w_fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.D[i]) begin
                w_fix_idx = W'(i);
            end
        end
    end

    // Scan downward in distance from the pointer so the nearest request wins.
    always_comb begin
        w_rr_idx   = '0;
        w_scan_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_scan_idx = {1'b0, w_p_scan} + (W + 1)'(k);
            if (w_scan_idx >= (W + 1)'(N)) begin
                w_scan_idx = w_scan_idx - (W + 1)'(N);
            end
            if (bus.D[w_scan_idx[W-1:0]]) begin
                w_rr_idx = w_scan_idx[W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_multi_nxt = r_multi;
        w_p_nxt     = r_p;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = HOLD;
                    w_s_nxt     = w_sel_idx;
                    w_multi_nxt = w_multi_hot;
                end
            end
            HOLD: begin
                if (bus.RDY) begin
                    w_p_nxt = w_p_scan;
                    if (w_load) begin
                        w_s_nxt     = w_sel_idx;
                        w_multi_nxt = w_multi_hot;
                    end else begin
                        w_state_nxt = IDLE;
                        w_multi_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_p     <= '0;
            r_multi <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_p     <= w_p_nxt;
            r_multi <= w_multi_nxt;
        end
    end

    assign bus.S     = r_s;
    assign bus.V     = (r_state == HOLD);
    assign bus.MULTI = r_multi;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: N=8 and N=6 instances against a behavioural model.
// Directed sequences pin literal grants, then randomized traffic with async reset pulses.
module tb_priority_encoder_rr;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   bg6    = 1'b0;

    priority_encoder_rr_if #(.N(8), .W(3)) bus8 ();
    priority_encoder_rr_if #(.N(6), .W(3)) bus6 ();

    priority_encoder_rr #(.N(8), .W(3)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    priority_encoder_rr #(.N(6), .W(3)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state per instance: 0 -> N=8, 1 -> N=6
    int m_p     [2] = '{0, 0};
    int m_s     [2] = '{0, 0};
    bit m_hold  [2] = '{0, 0};
    bit m_multi [2] = '{0, 0};

    function automatic int highest_set(input logic [7:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (d[i]) return i;
        end
        return 0;
    endfunction

    function automatic int rr_pick(input logic [7:0] d, input int n, input int p);
        int j;
        for (int k = 0; k < n; k++) begin
            j = (p + k) % n;
            if (d[j]) return j;
        end
        return 0;
    endfunction

    function automatic int ones(input logic [7:0] d, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(d[i]);
        return c;
    endfunction

    task automatic model_edge(input int u, input int n, input logic e,
                              input logic [7:0] d, input logic mode, input logic rdy);
        bit hs;
        bit load;
        hs   = m_hold[u] && rdy;
        load = e && (d != 8'h00);
        if (hs && mode) m_p[u] = (m_s[u] + 1) % n;
        if (!m_hold[u] || hs) begin
            if (load) begin
                m_s[u]     = mode ? rr_pick(d, n, m_p[u]) : highest_set(d, n);
                m_multi[u] = (ones(d, n) >= 2);
                m_hold[u]  = 1'b1;
            end else if (hs) begin
                m_hold[u]  = 1'b0;
                m_multi[u] = 1'b0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                m_p[u] = 0; m_s[u] = 0; m_hold[u] = 1'b0; m_multi[u] = 1'b0;
            end
        end else begin
            model_edge(0, 8, bus8.E, bus8.D, bus8.MODE, bus8.RDY);
            model_edge(1, 6, bus6.E, {2'b00, bus6.D}, bus6.MODE, bus6.RDY);
        end
    end

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("model_v8", int'(bus8.V), int'(m_hold[0]));
        cmp("model_multi8", int'(bus8.MULTI), int'(m_multi[0]));
        if (m_hold[0]) cmp("model_s8", int'(bus8.S), m_s[0]);
        cmp("model_v6", int'(bus6.V), int'(m_hold[1]));
        cmp("model_multi6", int'(bus6.MULTI), int'(m_multi[1]));
        if (m_hold[1]) cmp("model_s6", int'(bus6.S), m_s[1]);
    end

    task automatic drive8(input logic e, input logic [7:0] d, input logic m, input logic r);
        bus8.E = e; bus8.D = d; bus8.MODE = m; bus8.RDY = r;
    endtask

    task automatic drive6(input logic e, input logic [5:0] d, input logic m, input logic r);
        bus6.E = e; bus6.D = d; bus6.MODE = m; bus6.RDY = r;
    endtask

    function automatic logic [7:0] rand_vec();
        case ($urandom % 4)
            0:       return 8'h00;
            1:       return 8'h01 << ($urandom % 8);
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic rand6();
        logic [7:0] v;
        v = rand_vec();
        drive6(($urandom % 5) != 0, v[5:0], 1'($urandom % 2), ($urandom % 3) != 0);
    endtask

    task automatic rand8();
        drive8(($urandom % 5) != 0, rand_vec(), 1'($urandom % 2), ($urandom % 3) != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (bg6) rand6();
    endtask

    int exp8 [5];
    int exp6 [4];

    initial begin
        rst = 1'b1;
        drive8(1'b1, 8'hFF, 1'b0, 1'b1);
        drive6(1'b0, 6'h00, 1'b0, 1'b1);
        exp8 = '{0, 2, 7, 0, 2};
        exp6 = '{0, 5, 0, 5};

        // Reset held with live requests
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("rst_s", int'(bus8.S), 0);
            cmp("rst_v", int'(bus8.V), 0);
            cmp("rst_multi", int'(bus8.MULTI), 0);
        end
        rst = 1'b0;
        tick();
        cmp("first_load_s", int'(bus8.S), 7);
        cmp("first_load_v", int'(bus8.V), 1);

        // Walking one, fixed priority, back-to-back
        for (int i = 0; i < 8; i++) begin
            drive8(1'b1, 8'h01 << i, 1'b0, 1'b1);
            tick();
            cmp("walk_s", int'(bus8.S), i);
            cmp("walk_v", int'(bus8.V), 1);
            cmp("walk_multi", int'(bus8.MULTI), 0);
        end

        drive8(1'b1, 8'b0100_0100, 1'b0, 1'b1);
        tick();
        cmp("multi_s", int'(bus8.S), 6);
        cmp("multi_flag", int'(bus8.MULTI), 1);
        drive8(1'b1, 8'b0010_0000, 1'b0, 1'b1);
        tick();
        cmp("single_s", int'(bus8.S), 5);
        cmp("single_flag", int'(bus8.MULTI), 0);

        // Backpressure holds the grant
        drive8(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        cmp("drain_v", int'(bus8.V), 0);
        drive8(1'b1, 8'h04, 1'b0, 1'b0);
        tick();
        cmp("hold_load_s", int'(bus8.S), 2);
        drive8(1'b1, 8'h80, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            cmp("hold_s", int'(bus8.S), 2);
            cmp("hold_v", int'(bus8.V), 1);
        end
        drive8(1'b1, 8'h80, 1'b0, 1'b1);
        tick();
        cmp("release_s", int'(bus8.S), 7);

        // Round-robin rotation on both widths
        drive8(1'b1, 8'b1000_0101, 1'b1, 1'b1);
        drive6(1'b1, 6'b10_0001, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            cmp("rr8_s", int'(bus8.S), exp8[k]);
            cmp("rr8_v", int'(bus8.V), 1);
            if (k < 4) begin
                cmp("rr6_s", int'(bus6.S), exp6[k]);
                cmp("rr6_v", int'(bus6.V), 1);
            end
        end
        bg6 = 1'b1;

        // Enable low blocks loads; async reset mid-hold; pointer restarts at 0
        drive8(1'b0, 8'h10, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            cmp("en_low_v", int'(bus8.V), 0);
        end
        drive8(1'b1, 8'h10, 1'b0, 1'b0);
        tick();
        cmp("pre_rst_s", int'(bus8.S), 4);
        #1 rst = 1'b1;
        #1;
        cmp("async_rst_v", int'(bus8.V), 0);
        cmp("async_rst_s", int'(bus8.S), 0);
        rst = 1'b0;
        drive8(1'b1, 8'h11, 1'b1, 1'b1);
        tick();
        cmp("ptr_reset_s", int'(bus8.S), 0);
        cmp("ptr_reset_multi", int'(bus8.MULTI), 1);

        // Randomized traffic with occasional asynchronous reset pulses
        for (int c = 0; c < 1500; c++) begin
            rand8();
            tick();
            if (($urandom % 150) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
